// File: rtl/mem_arbiter.sv
// Arbiter that shares one single-port memory between instruction fetch and the MEM stage.
// MEM wins by default; a starve counter forces a fetch grant, and a wait counter times out stuck accesses.
module mem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MAX_WAIT   = 15,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              mem_req,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_valid,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              err
);

  localparam int WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam int STARVE_W = $clog2(STARVE_LIM + 1);
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_ACC  = 2'd1,
    MEM_ACC = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_grant_if;
  logic                w_grant_mem;
  logic                w_done;
  logic                w_timeout;
  logic                r_ram_req;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_mem_rdata;
  logic                r_if_valid;
  logic                r_mem_valid;
  logic                r_err;
  logic [WAIT_W-1:0]   r_wait;
  logic [STARVE_W-1:0] r_starve;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and grant/completion decode; no grant while a valid pulse is still out
  always_comb begin
    w_next      = r_state;
    w_grant_if  = 1'b0;
    w_grant_mem = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_if_valid || r_mem_valid) begin
          w_next = IDLE;
        end else if (mem_req && (r_starve < STARVE_MAX)) begin
          w_next      = MEM_ACC;
          w_grant_mem = 1'b1;
        end else if (if_req) begin
          w_next     = IF_ACC;
          w_grant_if = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      IF_ACC, MEM_ACC: begin
        if (ram_ready) begin
          w_next = IDLE;
          w_done = 1'b1;
        end else if (r_wait == WAIT_LAST) begin
          w_next    = IDLE;
          w_timeout = 1'b1;
        end else begin
          w_next = r_state;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: memory-side request registers, results, counters and sticky error
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ram_req   <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= {ADDR_W{1'b0}};
      r_ram_wdata <= {DATA_W{1'b0}};
      r_if_rdata  <= {DATA_W{1'b0}};
      r_mem_rdata <= {DATA_W{1'b0}};
      r_if_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
      r_err       <= 1'b0;
      r_wait      <= {WAIT_W{1'b0}};
      r_starve    <= {STARVE_W{1'b0}};
    end else begin
      r_ram_req   <= (w_next == IF_ACC) || (w_next == MEM_ACC);
      r_if_valid  <= (w_done || w_timeout) && (r_state == IF_ACC);
      r_mem_valid <= (w_done || w_timeout) && (r_state == MEM_ACC);

      if (w_grant_mem) begin
        r_ram_addr  <= mem_addr;
        r_ram_we    <= mem_wr;
        r_ram_wdata <= mem_wdata;
      end else if (w_grant_if) begin
        r_ram_addr  <= if_addr;
        r_ram_we    <= 1'b0;
        r_ram_wdata <= {DATA_W{1'b0}};
      end else if (w_done || w_timeout) begin
        r_ram_we <= 1'b0;
      end

      if (w_grant_if || w_grant_mem) begin
        r_wait <= {WAIT_W{1'b0}};
      end else if ((r_state != IDLE) && !ram_ready) begin
        r_wait <= r_wait + WAIT_W'(1);
      end

      if (w_grant_if) begin
        r_starve <= {STARVE_W{1'b0}};
      end else if ((r_state == IDLE) && !if_req) begin
        r_starve <= {STARVE_W{1'b0}};
      end else if (w_grant_mem && (r_starve != STARVE_MAX)) begin
        r_starve <= r_starve + STARVE_W'(1);
      end

      // A write leaves mem_rdata untouched; a timeout returns zero data
      if (w_done && (r_state == IF_ACC)) begin
        r_if_rdata <= ram_rdata;
      end else if (w_timeout && (r_state == IF_ACC)) begin
        r_if_rdata <= {DATA_W{1'b0}};
      end
      if (w_done && (r_state == MEM_ACC) && !r_ram_we) begin
        r_mem_rdata <= ram_rdata;
      end else if (w_timeout && (r_state == MEM_ACC)) begin
        r_mem_rdata <= {DATA_W{1'b0}};
      end

      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign ram_req   = r_ram_req;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign mem_rdata = r_mem_rdata;
  assign mem_valid = r_mem_valid;
  assign err       = r_err;
  assign stall_if  = if_req & ~r_if_valid;
  assign stall_mem = mem_req & ~r_mem_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, load/store, contention, timeout, mid-access reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_wr, ram_ready;
  logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
  logic        ram_req, ram_we, if_valid, mem_valid, stall_if, stall_mem, err;
  logic [31:0] ram_addr, ram_wdata, if_rdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(15), .STARVE_LIM(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int          stall_cnt, vcnt, valid_cyc, ng, rq, acc;
    logic        prev, got;
    logic [31:0] grants [5];

    rst = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_wr = 1'b0; ram_ready = 1'b0;
    if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0; ram_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_ram_req", ram_req, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_valids", {if_valid, mem_valid}, 2'b00);
    check("rst_rdata", {if_rdata, mem_rdata}, 64'h0);
    check("rst_err", err, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // Single fetch, memory ready in the first access cycle
    if_req = 1'b1; if_addr = 32'h40; ram_ready = 1'b1; ram_rdata = 32'h1122_3344;
    stall_cnt = 0; vcnt = 0; valid_cyc = -1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (stall_if) stall_cnt++;
      if (c == 1) begin
        check("fetch_ram_req", ram_req, 1'b1);
        check("fetch_ram_addr", ram_addr, 32'h40);
        check("fetch_ram_we", ram_we, 1'b0);
      end
      if (if_valid) begin
        vcnt++;
        if (valid_cyc < 0) begin
          valid_cyc = c;
          check("fetch_rdata", if_rdata, 32'h1122_3344);
        end
        if_req = 1'b0;
      end
      @(negedge clk);
    end
    check("fetch_valid_cycle", valid_cyc, 2);
    check("fetch_valid_count", vcnt, 1);
    check("fetch_stall_cycles", stall_cnt, 2);

    // Load so that mem_rdata holds a known value
    mem_req = 1'b1; mem_wr = 1'b0; mem_addr = 32'h80; ram_rdata = 32'hA5A5_0001;
    repeat (2) @(negedge clk);
    check("load_valid", mem_valid, 1'b1);
    check("load_rdata", mem_rdata, 32'hA5A5_0001);
    mem_req = 1'b0; ram_ready = 1'b0;
    @(negedge clk);

    // Store with one wait cycle; request fields must stay latched
    mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hCAFE_F00D;
    ram_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("store_req_we", {ram_req, ram_we}, 2'b11);
    check("store_addr", ram_addr, 32'h100);
    check("store_wdata", ram_wdata, 32'hCAFE_F00D);
    mem_addr = 32'h999; mem_wdata = 32'h0;
    @(negedge clk);
    check("store_hold_addr", ram_addr, 32'h100);
    check("store_hold_wdata", ram_wdata, 32'hCAFE_F00D);
    check("store_hold_we", ram_we, 1'b1);
    check("store_stall_mem", stall_mem, 1'b1);
    ram_ready = 1'b1;
    @(negedge clk);
    check("store_valid", mem_valid, 1'b1);
    check("store_rdata_held", mem_rdata, 32'hA5A5_0001);
    check("store_req_drop", ram_req, 1'b0);
    check("store_stall_clear", stall_mem, 1'b0);
    mem_req = 1'b0; mem_wr = 1'b0;
    @(negedge clk);
    check("store_valid_pulse", mem_valid, 1'b0);

    // Contention with ram_ready always 1: three MEM grants, then IF is forced
    if_addr = 32'h200; mem_addr = 32'h300; if_req = 1'b1; mem_req = 1'b1;
    prev = 1'b0; ng = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ram_req && !prev && ng < 5) begin
        grants[ng] = ram_addr;
        ng++;
      end
      prev = ram_req;
    end
    check("cont_num_grants", ng, 5);
    check("cont_grant0", grants[0], 32'h300);
    check("cont_grant1", grants[1], 32'h300);
    check("cont_grant2", grants[2], 32'h300);
    check("cont_grant3", grants[3], 32'h200);
    check("cont_grant4", grants[4], 32'h300);
    if_req = 1'b0; mem_req = 1'b0; ram_ready = 1'b0;
    repeat (4) @(negedge clk);

    // Timeout on a fetch
    if_req = 1'b1; if_addr = 32'h44; rq = 0; got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ram_req) rq++;
      if (if_valid) begin
        got = 1'b1;
        check("tmo_rdata", if_rdata, 32'h0);
        check("tmo_err", err, 1'b1);
        if_req = 1'b0;
        break;
      end
    end
    check("tmo_valid_seen", got, 1'b1);
    check("tmo_req_cycles", rq, 15);
    repeat (3) @(negedge clk);
    check("tmo_err_sticky", err, 1'b1);

    // Reset in the second MEM_ACC cycle
    mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 32'h104; mem_wdata = 32'h55;
    repeat (2) @(negedge clk);
    check("mrst_in_acc", ram_req, 1'b1);
    rst = 1'b0; mem_req = 1'b0; mem_wr = 1'b0;
    @(negedge clk);
    check("mrst_ram_req", ram_req, 1'b0);
    check("mrst_ram_we", ram_we, 1'b0);
    check("mrst_mem_valid", mem_valid, 1'b0);
    check("mrst_err", err, 1'b0);
    check("mrst_addr_wdata", {ram_addr, ram_wdata}, 64'h0);
    check("mrst_rdata", {if_rdata, mem_rdata}, 64'h0);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_no_pulse", {mem_valid, ram_req}, 2'b00);

    // ram_ready in the timeout cycle wins
    if_req = 1'b1; if_addr = 32'h48; ram_rdata = 32'h0BAD_CAFE; acc = 0; got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ram_req) begin
        acc++;
        if (acc == 15) ram_ready = 1'b1;
      end
      if (if_valid) begin
        got = 1'b1;
        check("prio_rdata", if_rdata, 32'h0BAD_CAFE);
        check("prio_err", err, 1'b0);
        break;
      end
    end
    check("prio_valid_seen", got, 1'b1);
    check("prio_acc_cycles", acc, 15);
    if_req = 1'b0; ram_ready = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
